// File: rtl/vga_sync_timer.sv
// VGA raster timing generator: pixel-rate enable, sync pulses, display flag and
// pixel coordinates, all flop-driven from a single board_clk domain.
module vga_sync_timer #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       board_clk,
  input  logic       reset,
  output logic       pix_en,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       inDisplayArea,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic             pix_nxt;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;

  // Flags are derived from the values the counters are about to take, so the
  // registered flags line up with the registered coordinates.
  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_nxt = (div_nxt == DIV_LAST);
    x_nxt   = CounterX;
    y_nxt   = CounterY;
    if (pix_en) begin
      if (CounterX == H_LAST) begin
        x_nxt = '0;
        y_nxt = (CounterY == V_LAST) ? '0 : CounterY + 10'd1;
      end else begin
        x_nxt = CounterX + 10'd1;
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      pix_en        <= 1'b0;
      frame_tick    <= 1'b0;
      CounterX      <= '0;
      CounterY      <= '0;
      vga_h_sync    <= ~SYNC_POL;
      vga_v_sync    <= ~SYNC_POL;
      inDisplayArea <= 1'b0;
    end else begin
      div_q      <= div_nxt;
      pix_en     <= pix_nxt;
      // High alongside the pix_en pulse that carries the raster from the last
      // pixel of the frame back to (0,0).
      frame_tick <= pix_nxt && (x_nxt == H_LAST) && (y_nxt == V_LAST);
      if (pix_en) begin
        CounterX      <= x_nxt;
        CounterY      <= y_nxt;
        vga_h_sync    <= sync_level(in_range(x_nxt, HS_START, HS_END));
        vga_v_sync    <= sync_level(in_range(y_nxt, VS_START, VS_END));
        inDisplayArea <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_timer.sv
// Bench for vga_sync_timer: a default-timing instance (PIX_DIV=4) and a tiny
// raster instance (PIX_DIV=1, active-high syncs) driven from one clock.
module tb_vga_sync_timer;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;

  logic       a_pe, a_hs, a_vs, a_de, a_ft;
  logic [9:0] a_x, a_y;
  logic       b_pe, b_hs, b_vs, b_de, b_ft;
  logic [9:0] b_x, b_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_timer dut_a (
    .board_clk(clk), .reset(rst_a), .pix_en(a_pe), .vga_h_sync(a_hs),
    .vga_v_sync(a_vs), .inDisplayArea(a_de), .CounterX(a_x), .CounterY(a_y),
    .frame_tick(a_ft)
  );

  // 16 x 10 raster: h_sync on X 10..12, v_sync on Y 7..8, visible 8 x 6.
  vga_sync_timer #(
    .PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .board_clk(clk), .reset(rst_b), .pix_en(b_pe), .vga_h_sync(b_hs),
    .vga_v_sync(b_vs), .inDisplayArea(b_de), .CounterX(b_x), .CounterY(b_y),
    .frame_tick(b_ft)
  );

  typedef struct packed {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ft;
  } vec_t;

  vec_t tbl [23];

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkc(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chkc({tag, " a X"}, a_x, 10'd0);
    chkc({tag, " a Y"}, a_y, 10'd0);
    chkb({tag, " a hs"}, a_hs, 1'b1);
    chkb({tag, " a vs"}, a_vs, 1'b1);
    chkb({tag, " a de"}, a_de, 1'b0);
    chkb({tag, " a pe"}, a_pe, 1'b0);
    chkb({tag, " a ft"}, a_ft, 1'b0);
  endtask

  task automatic chk_b_reset(input string tag);
    chkc({tag, " b X"}, b_x, 10'd0);
    chkc({tag, " b Y"}, b_y, 10'd0);
    chkb({tag, " b hs"}, b_hs, 1'b0);
    chkb({tag, " b vs"}, b_vs, 1'b0);
    chkb({tag, " b de"}, b_de, 1'b0);
    chkb({tag, " b pe"}, b_pe, 1'b0);
    chkb({tag, " b ft"}, b_ft, 1'b0);
  endtask

  initial begin
    int cur;
    int hs_low, vs_low, de_hi, pe_cnt, ft_cnt, de_bad;
    logic [9:0] hs_min, hs_max;

    //        n    X  Y  hs vs de ft   (n = board_clk edges after release)
    tbl[0]  = '{1,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2,   1, 0, 0, 0, 1, 0};
    tbl[2]  = '{8,   7, 0, 0, 0, 1, 0};
    tbl[3]  = '{9,   8, 0, 0, 0, 0, 0};
    tbl[4]  = '{11, 10, 0, 1, 0, 0, 0};
    tbl[5]  = '{13, 12, 0, 1, 0, 0, 0};
    tbl[6]  = '{14, 13, 0, 0, 0, 0, 0};
    tbl[7]  = '{16, 15, 0, 0, 0, 0, 0};
    tbl[8]  = '{17,  0, 1, 0, 0, 1, 0};
    tbl[9]  = '{88,  7, 5, 0, 0, 1, 0};
    tbl[10] = '{89,  8, 5, 0, 0, 0, 0};
    tbl[11] = '{96, 15, 5, 0, 0, 0, 0};
    tbl[12] = '{97,  0, 6, 0, 0, 0, 0};
    tbl[13] = '{113, 0, 7, 0, 1, 0, 0};
    tbl[14] = '{126, 13, 7, 0, 1, 0, 0};
    tbl[15] = '{128, 15, 7, 0, 1, 0, 0};
    tbl[16] = '{129, 0, 8, 0, 1, 0, 0};
    tbl[17] = '{144, 15, 8, 0, 1, 0, 0};
    tbl[18] = '{145, 0, 9, 0, 0, 0, 0};
    tbl[19] = '{159, 14, 9, 0, 0, 0, 0};
    tbl[20] = '{160, 15, 9, 0, 0, 0, 1};
    tbl[21] = '{161, 0, 0, 0, 0, 1, 0};
    tbl[22] = '{320, 15, 9, 0, 0, 0, 1};

    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk_a_reset("por");
    chk_b_reset("por");
    repeat (3) @(negedge clk);
    chk_a_reset("held");

    // Default instance: first pixel enable and first counter step.
    rst_a = 1'b0;
    step(2);
    chkb("a pe edge2", a_pe, 1'b0);
    step(1);
    chkb("a pe edge3", a_pe, 1'b1);
    chkc("a X edge3", a_x, 10'd0);
    chkb("a de edge3", a_de, 1'b0);
    step(1);
    chkb("a pe edge4", a_pe, 1'b0);
    chkc("a X edge4", a_x, 10'd1);
    chkc("a Y edge4", a_y, 10'd0);
    chkb("a de edge4", a_de, 1'b1);
    chkb("a hs edge4", a_hs, 1'b1);
    chkb("a vs edge4", a_vs, 1'b1);

    step(3195);
    chkc("a X edge3199", a_x, 10'd799);
    chkc("a Y edge3199", a_y, 10'd0);
    chkb("a de X799", a_de, 1'b0);
    step(1);
    chkc("a X wrap", a_x, 10'd0);
    chkc("a Y wrap", a_y, 10'd1);
    chkb("a de X0Y1", a_de, 1'b1);

    // Whole line Y=1 sampled every board_clk.
    hs_low = 0; vs_low = 0; de_hi = 0; pe_cnt = 0; ft_cnt = 0; de_bad = 0;
    hs_min = 10'd1023; hs_max = 10'd0;
    for (int i = 0; i < 3200; i++) begin
      if (i > 0) step(1);
      if (a_hs === 1'b0) begin
        hs_low++;
        if (a_x < hs_min) hs_min = a_x;
        if (a_x > hs_max) hs_max = a_x;
      end
      if (a_vs === 1'b0) vs_low++;
      if (a_de === 1'b1) de_hi++;
      if (a_pe === 1'b1) pe_cnt++;
      if (a_ft === 1'b1) ft_cnt++;
      if (a_de !== ((a_x < 10'd640) && (a_y < 10'd480))) de_bad++;
    end
    chkn("a hs low cycles", hs_low, 384);
    chkc("a hs first X", hs_min, 10'd656);
    chkc("a hs last X", hs_max, 10'd751);
    chkn("a vs low cycles", vs_low, 0);
    chkn("a de high cycles", de_hi, 2560);
    chkn("a pe per line", pe_cnt, 800);
    chkn("a ft in line", ft_cnt, 0);
    chkn("a de vs coords", de_bad, 0);
    chkc("a X end line1", a_x, 10'd799);
    step(1);
    chkc("a X start line2", a_x, 10'd0);
    chkc("a Y start line2", a_y, 10'd2);

    // Reset in the middle of the h_sync pulse, between clock edges.
    step(2803);
    chkc("a X pre-reset", a_x, 10'd700);
    chkb("a hs pre-reset", a_hs, 1'b0);
    chkb("a pe pre-reset", a_pe, 1'b1);
    #1 rst_a = 1'b1;
    #1;
    chk_a_reset("async");

    // Small instance: table of raster positions.
    @(negedge clk);
    chk_b_reset("b held");
    rst_b = 1'b0;
    cur = 0;
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].n - cur);
      cur = tbl[i].n;
      chkb($sformatf("b pe n=%0d", cur), b_pe, 1'b1);
      chkc($sformatf("b X n=%0d", cur), b_x, tbl[i].x);
      chkc($sformatf("b Y n=%0d", cur), b_y, tbl[i].y);
      chkb($sformatf("b hs n=%0d", cur), b_hs, tbl[i].hs);
      chkb($sformatf("b vs n=%0d", cur), b_vs, tbl[i].vs);
      chkb($sformatf("b de n=%0d", cur), b_de, tbl[i].de);
      chkb($sformatf("b ft n=%0d", cur), b_ft, tbl[i].ft);
    end

    ft_cnt = 0;
    for (int i = 0; i < 320; i++) begin
      step(1);
      if (b_ft === 1'b1) ft_cnt++;
    end
    chkn("b ft per 2 frames", ft_cnt, 2);

    // Reset while both syncs are active, then restart from divider 0.
    rst_b = 1'b1;
    step(2);
    rst_b = 1'b0;
    step(124);
    chkc("b X pre-reset", b_x, 10'd11);
    chkc("b Y pre-reset", b_y, 10'd7);
    chkb("b hs pre-reset", b_hs, 1'b1);
    chkb("b vs pre-reset", b_vs, 1'b1);
    #1 rst_b = 1'b1;
    #1;
    chk_b_reset("b async");
    @(negedge clk);
    rst_b = 1'b0;
    step(1);
    chkb("b pe restart", b_pe, 1'b1);
    chkc("b X restart1", b_x, 10'd0);
    chkb("b de restart1", b_de, 1'b0);
    step(1);
    chkc("b X restart2", b_x, 10'd1);
    chkb("b de restart2", b_de, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
